// File: rtl/usb_piso_tr_arbiter_pkg.sv
// Shared types and constants for the PISO-to-USB_TR arbiter.
// Holds the request-type width, the FSM state encoding and the index-width helper.
package usb_piso_tr_arbiter_pkg;

  localparam int REQUEST_SERIAL_DATA_TYPE_WIDTH = 2;

  typedef enum logic [1:0] {
    USB_ARB_IDLE    = 2'd0,
    USB_ARB_GRANTED = 2'd1,
    USB_ARB_ACTIVE  = 2'd2
  } usb_arb_state_e;

  // Width of a channel index; a single channel still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/usb_rr_arbiter.sv
// Combinational winner selection: round-robin from a pointer, or fixed
// priority with index 0 highest.
module usb_rr_arbiter
  import usb_piso_tr_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int GW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  input  logic          rr_mode,
  output logic [GW-1:0] winner,
  output logic          valid
);

  logic [GW-1:0] cand;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    winner = '0;
    cand   = '0;
    valid  = |req;
    for (int k = N - 1; k >= 0; k--) begin
      if (rr_mode) begin
        cand = GW'((int'(ptr) + k) % N);
      end else begin
        cand = GW'(k);
      end
      if (req[cand]) begin
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/usb_piso_tr_arbiter.sv
// N PISO serialisers sharing one USB_TR: grant locked for a whole transfer,
// registered data path back to USB_TR, and a stall watchdog.
module usb_piso_tr_arbiter
  import usb_piso_tr_arbiter_pkg::*;
#(
  parameter int NUMBER_OF_PISO = 4,
  parameter int REQ_TYPE_WIDTH = REQUEST_SERIAL_DATA_TYPE_WIDTH,
  parameter int RR_MODE        = 1,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int GW = idx_width(NUMBER_OF_PISO)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUMBER_OF_PISO-1:0]                piso_data_out,
  input  logic [NUMBER_OF_PISO-1:0]                piso_data_val,
  input  logic [NUMBER_OF_PISO-1:0]                piso_data_last,
  input  logic [NUMBER_OF_PISO-1:0]                piso_serial_data_avail,
  output logic [NUMBER_OF_PISO-1:0]                piso_request_serial_data,
  output logic [NUMBER_OF_PISO*REQ_TYPE_WIDTH-1:0] piso_request_serial_data_type,
  output logic                                     usb_tr_piso_data_out,
  output logic                                     usb_tr_piso_data_val,
  output logic                                     usb_tr_piso_data_last,
  output logic                                     usb_tr_piso_serial_data_avail,
  input  logic                                     usb_tr_request_serial_data,
  input  logic [REQ_TYPE_WIDTH-1:0]                usb_tr_request_serial_data_type,
  output logic [GW-1:0]                            grant_idx,
  output logic                                     busy,
  output logic                                     timeout_err
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GW-1:0] LAST_IDX = GW'(NUMBER_OF_PISO - 1);

  usb_arb_state_e state_reg, state_next;
  logic [GW-1:0]  grant_idx_reg, grant_idx_next;
  logic [GW-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [CW-1:0]  wd_cnt_reg, wd_cnt_next;
  logic           data_out_reg, data_val_reg, data_last_reg;

  logic [GW-1:0]  arb_winner;
  logic           arb_valid;
  logic           owner_val, owner_done, wd_expire, fwd_req;
  logic [GW-1:0]  ptr_adv;

  usb_rr_arbiter #(.N(NUMBER_OF_PISO)) u_arb (
    .req     (piso_serial_data_avail),
    .ptr     (rr_ptr_reg),
    .rr_mode (RR_MODE != 0),
    .winner  (arb_winner),
    .valid   (arb_valid)
  );

  assign owner_val  = piso_data_val[grant_idx_reg];
  assign owner_done = owner_val & piso_data_last[grant_idx_reg];
  assign ptr_adv    = (grant_idx_reg == LAST_IDX) ? '0 : grant_idx_reg + 1'b1;

  // A data-valid cycle never expires, so completion always beats the watchdog.
  assign wd_expire = (TIMEOUT_CYCLES != 0) && (state_reg == USB_ARB_ACTIVE) && !owner_val &&
                     (wd_cnt_reg == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_next                    = state_reg;
    grant_idx_next                = grant_idx_reg;
    rr_ptr_next                   = rr_ptr_reg;
    wd_cnt_next                   = '0;
    fwd_req                       = 1'b0;
    usb_tr_piso_serial_data_avail = 1'b0;
    case (state_reg)
      USB_ARB_IDLE: begin
        if (arb_valid) begin
          grant_idx_next = arb_winner;
          state_next     = USB_ARB_GRANTED;
        end
      end
      USB_ARB_GRANTED: begin
        usb_tr_piso_serial_data_avail = piso_serial_data_avail[grant_idx_reg];
        fwd_req                       = usb_tr_request_serial_data;
        if (usb_tr_request_serial_data) begin
          state_next = USB_ARB_ACTIVE;
        end else if (!piso_serial_data_avail[grant_idx_reg]) begin
          state_next = USB_ARB_IDLE;
        end
      end
      USB_ARB_ACTIVE: begin
        usb_tr_piso_serial_data_avail = 1'b1;
        fwd_req                       = usb_tr_request_serial_data & ~wd_expire;
        if (owner_done || wd_expire) begin
          state_next = USB_ARB_IDLE;
          if (RR_MODE != 0) begin
            rr_ptr_next = ptr_adv;
          end
        end else if (!owner_val) begin
          wd_cnt_next = wd_cnt_reg + 1'b1;
        end
      end
      default: state_next = USB_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= USB_ARB_IDLE;
      grant_idx_reg <= '0;
      rr_ptr_reg    <= '0;
      wd_cnt_reg    <= '0;
      data_out_reg  <= 1'b0;
      data_val_reg  <= 1'b0;
      data_last_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      grant_idx_reg <= grant_idx_next;
      rr_ptr_reg    <= rr_ptr_next;
      wd_cnt_reg    <= wd_cnt_next;
      if (state_reg == USB_ARB_ACTIVE) begin
        data_out_reg  <= piso_data_out[grant_idx_reg];
        data_val_reg  <= owner_val;
        data_last_reg <= piso_data_last[grant_idx_reg];
      end else begin
        data_out_reg  <= 1'b0;
        data_val_reg  <= 1'b0;
        data_last_reg <= 1'b0;
      end
    end
  end

  // Request and type reach the owning channel only.
  for (genvar gi = 0; gi < NUMBER_OF_PISO; gi++) begin : g_route
    logic sel;
    assign sel = fwd_req && (grant_idx_reg == GW'(gi));
    assign piso_request_serial_data[gi] = sel;
    assign piso_request_serial_data_type[gi*REQ_TYPE_WIDTH +: REQ_TYPE_WIDTH] =
      sel ? usb_tr_request_serial_data_type : '0;
  end

  assign usb_tr_piso_data_out  = data_out_reg;
  assign usb_tr_piso_data_val  = data_val_reg;
  assign usb_tr_piso_data_last = data_last_reg;
  assign grant_idx             = grant_idx_reg;
  assign busy                  = (state_reg != USB_ARB_IDLE);
  assign timeout_err           = wd_expire;

endmodule
